// File: rtl/boot_pkg.sv
// Shared types and frame constants for the UART boot loader.
// Imported by boot_ctrl and its timeout sub-module.
package boot_pkg;

   typedef enum logic [2:0] {
      WAIT_MAGIC,
      ADDR,
      LEN,
      DATA,
      CSUM,
      DONE,
      RUN
   } boot_state_e;

   localparam logic [7:0] BOOT_MAGIC = 8'hA5;
   localparam int unsigned ADDR_BYTES = 4;
   localparam int unsigned LEN_BYTES  = 2;

   function automatic logic is_rx_state(boot_state_e s);
      return (s != DONE) && (s != RUN);
   endfunction

endpackage

// File: rtl/boot_timeout.sv
// Idle timeout counter: clears on clr, counts while en,
// flags expiry on its TIMEOUT_CYCLES-th counted cycle.
module boot_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   assign expired = en && (cnt_q == LIM);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/boot_ctrl.sv
// UART boot loader: parses A5/addr/len/data/csum frames into IMEM
// and holds the CPU in reset until a good image or idle timeout.
module boot_ctrl
   import boot_pkg::*;
#(
   parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
   parameter logic [31:0] RESET_PC       = 32'h1000_0000,
   parameter int unsigned IMEM_AW        = 14,
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               boot_req,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_din,
   output logic [3:0]         imem_we,
   output logic               cpu_rst,
   output logic [31:0]        cpu_start_pc,
   output logic               busy,
   output logic               error
);

   localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
   localparam logic [1:0] LEN_LAST  = 2'(LEN_BYTES - 1);

   if (CPU_CLOCK_FREQ == 0) begin : g_freq_chk
      $error("boot_ctrl: CPU_CLOCK_FREQ must be nonzero");
   end

   boot_state_e        state_q, state_d;
   logic [1:0]         cnt_q;
   logic [31:0]        addr_q;
   logic [15:0]        len_q;
   logic [15:0]        widx_q;
   logic [23:0]        word_q;
   logic [7:0]         sum_q;
   logic               rx_ready_q;
   logic               cpu_rst_q;
   logic [31:0]        pc_q;
   logic               err_q;
   logic [3:0]         we_q;
   logic [IMEM_AW-1:0] iaddr_q;
   logic [31:0]        din_q;

   logic       accept;
   logic       expired;
   logic       tmo_en;
   logic       tmo_clr;
   logic [7:0] sum_nx;
   logic       last_word;

   assign accept    = rx_valid && rx_ready_q;
   assign sum_nx    = sum_q + rx_data;
   assign last_word = (widx_q == len_q - 16'd1);
   assign tmo_en    = is_rx_state(state_q);
   // expiry always causes a state change, so it restarts the count too
   assign tmo_clr   = accept || expired || !tmo_en;

   boot_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expired(expired)
   );

   always_comb begin
      state_d = state_q;
      if (state_q == DONE) begin
         state_d = RUN;
      end else if (state_q == RUN) begin
         if (boot_req) state_d = WAIT_MAGIC;
      end else if (accept) begin
         unique case (state_q)
            WAIT_MAGIC: if (rx_data == BOOT_MAGIC) state_d = ADDR;
            ADDR:       if (cnt_q == ADDR_LAST) state_d = LEN;
            LEN: begin
               if (cnt_q == LEN_LAST)
                  state_d = ({rx_data, len_q[15:8]} != 16'd0) ? DATA : CSUM;
            end
            DATA:       if (cnt_q == 2'd3 && last_word) state_d = CSUM;
            CSUM:       state_d = (rx_data == sum_q) ? DONE : WAIT_MAGIC;
            default:    state_d = WAIT_MAGIC;
         endcase
      end else if (expired) begin
         state_d = (state_q == WAIT_MAGIC) ? RUN : WAIT_MAGIC;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= WAIT_MAGIC;
         cnt_q      <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         widx_q     <= '0;
         word_q     <= '0;
         sum_q      <= '0;
         rx_ready_q <= 1'b0;
         cpu_rst_q  <= 1'b1;
         pc_q       <= RESET_PC;
         err_q      <= 1'b0;
         we_q       <= '0;
         iaddr_q    <= '0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         rx_ready_q <= is_rx_state(state_d);
         cpu_rst_q  <= (state_d != RUN);
         we_q       <= '0;
         if (accept) begin
            unique case (state_q)
               WAIT_MAGIC: begin
                  sum_q <= '0;
                  cnt_q <= '0;
               end
               ADDR: begin
                  addr_q <= {rx_data, addr_q[31:8]};
                  sum_q  <= sum_nx;
                  cnt_q  <= cnt_q + 2'd1;
               end
               LEN: begin
                  len_q  <= {rx_data, len_q[15:8]};
                  sum_q  <= sum_nx;
                  cnt_q  <= (cnt_q == LEN_LAST) ? 2'd0 : cnt_q + 2'd1;
                  widx_q <= '0;
               end
               DATA: begin
                  word_q <= {rx_data, word_q[23:8]};
                  sum_q  <= sum_nx;
                  cnt_q  <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     we_q    <= 4'hF;
                     iaddr_q <= addr_q[IMEM_AW+1:2] + IMEM_AW'(widx_q);
                     din_q   <= {rx_data, word_q};
                     widx_q  <= widx_q + 16'd1;
                  end
               end
               CSUM: begin
                  if (rx_data == sum_q) begin
                     pc_q  <= addr_q & ~32'h3;
                     err_q <= 1'b0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (expired && state_q != WAIT_MAGIC) begin
            err_q <= 1'b1;
         end
      end
   end

   assign rx_ready     = rx_ready_q;
   assign imem_addr    = iaddr_q;
   assign imem_din     = din_q;
   assign imem_we      = we_q;
   assign cpu_rst      = cpu_rst_q;
   assign busy         = cpu_rst_q;
   assign cpu_start_pc = pc_q;
   assign error        = err_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: frame table plus timeout,
// boot_req and mid-frame reset sequences.
module tb_boot_ctrl;

   localparam logic [31:0] RPC = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        boot_req = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [13:0] imem_addr;
   logic [31:0] imem_din;
   logic [3:0]  imem_we;
   logic        cpu_rst;
   logic [31:0] cpu_start_pc;
   logic        busy;
   logic        error;

   int n_chk = 0;
   int n_err = 0;

   logic [13:0] wa [8];
   logic [31:0] wd [8];
   logic [3:0]  wwe [8];
   int          nwr = 0;

   always #5 clk = ~clk;

   boot_ctrl #(
      .CPU_CLOCK_FREQ(50_000_000),
      .RESET_PC      (RPC),
      .IMEM_AW       (14),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .boot_req    (boot_req),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .imem_addr   (imem_addr),
      .imem_din    (imem_din),
      .imem_we     (imem_we),
      .cpu_rst     (cpu_rst),
      .cpu_start_pc(cpu_start_pc),
      .busy        (busy),
      .error       (error)
   );

   always @(negedge clk) begin
      if (rst && imem_we != 4'h0 && nwr < 8) begin
         wa[nwr]  = imem_addr;
         wd[nwr]  = imem_din;
         wwe[nwr] = imem_we;
         nwr      = nwr + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after acceptance
   task automatic send_byte(input logic [7:0] b);
      bit ok = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         if (rx_ready === 1'b1) begin
            ok = 1;
            @(posedge clk);
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_chk++;
         n_err++;
         $display("FAIL send_byte: byte %h not accepted in 20 cycles", b);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      rx_valid = 1'b0;
      boot_req = 1'b0;
      #1;
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_pc", cpu_start_pc, RPC);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_din", imem_din, 32'd0);
      chk("rst_rdy", 32'(rx_ready), 32'd0);
      nwr = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_rdy", 32'(rx_ready), 32'd1);
   endtask

   typedef struct {
      logic [191:0] frm;
      int           nb;
      bit           rst_first;
      bit           exp_run;
      bit           exp_err;
      logic [31:0]  exp_pc;
      int           exp_nwr;
      logic [13:0]  wa0;
      logic [13:0]  wa1;
      logic [31:0]  wd0;
      logic [31:0]  wd1;
   } vec_t;

   vec_t tv [5];

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // checksum = 10+02+13+6F = 94 (mod 256)
      tv[0] = '{frm: 192'({8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h02, 8'h00,
                           8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00,
                           8'h00, 8'h94}),
                nb: 16, rst_first: 1, exp_run: 1, exp_err: 0, exp_pc: RPC,
                exp_nwr: 2, wa0: 14'h0, wa1: 14'h1,
                wd0: 32'h13, wd1: 32'h6F};
      tv[1] = '{frm: 192'({8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h02, 8'h00,
                           8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00,
                           8'h00, 8'h93}),
                nb: 16, rst_first: 1, exp_run: 0, exp_err: 1, exp_pc: RPC,
                exp_nwr: 2, wa0: 14'h0, wa1: 14'h1,
                wd0: 32'h13, wd1: 32'h6F};
      tv[2] = tv[0];
      tv[2].rst_first = 0;
      tv[3] = '{frm: 192'({8'hA5, 8'h03, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'h05}),
                nb: 8, rst_first: 1, exp_run: 1, exp_err: 0,
                exp_pc: 32'h0000_0200, exp_nwr: 0, wa0: 14'h0, wa1: 14'h0,
                wd0: 32'h0, wd1: 32'h0};
      tv[4] = '{frm: 192'({8'h11, 8'h22, 8'hA5, 8'hFC, 8'hFF, 8'h01, 8'h00,
                           8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04,
                           8'h03, 8'h02, 8'h01, 8'h40}),
                nb: 18, rst_first: 1, exp_run: 1, exp_err: 0,
                exp_pc: 32'h0001_FFFC, exp_nwr: 2, wa0: 14'h3FFF,
                wa1: 14'h0000, wd0: 32'hDEAD_BEEF, wd1: 32'h0102_0304};

      for (int v = 0; v < 5; v++) begin
         if (tv[v].rst_first) do_reset();
         nwr = 0;
         for (int i = 0; i < tv[v].nb; i++)
            send_byte(tv[v].frm[8*(tv[v].nb-1-i) +: 8]);
         rx_valid = 1'b0;
         if (tv[v].exp_run) begin
            chk($sformatf("v%0d_done_rst", v), 32'(cpu_rst), 32'd1);
            chk($sformatf("v%0d_done_rdy", v), 32'(rx_ready), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_run_rst", v), 32'(cpu_rst), 32'd0);
            chk($sformatf("v%0d_run_busy", v), 32'(busy), 32'd0);
         end else begin
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_hold_rst", v), 32'(cpu_rst), 32'd1);
            chk($sformatf("v%0d_hold_rdy", v), 32'(rx_ready), 32'd1);
         end
         chk($sformatf("v%0d_err", v), 32'(error), 32'(tv[v].exp_err));
         chk($sformatf("v%0d_pc", v), cpu_start_pc, tv[v].exp_pc);
         chk($sformatf("v%0d_nwr", v), 32'(nwr), 32'(tv[v].exp_nwr));
         for (int w = 0; w < tv[v].exp_nwr && w < nwr; w++) begin
            chk($sformatf("v%0d_we%0d", v, w), 32'(wwe[w]), 32'hF);
            chk($sformatf("v%0d_wa%0d", v, w), 32'(wa[w]),
                32'(w == 0 ? tv[v].wa0 : tv[v].wa1));
            chk($sformatf("v%0d_wd%0d", v, w), wd[w],
                w == 0 ? tv[v].wd0 : tv[v].wd1);
         end
      end

      // idle after reset: cpu_rst falls on the 100th edge
      do_reset();
      repeat (98) @(negedge clk);
      chk("idle99_rst", 32'(cpu_rst), 32'd1);
      @(negedge clk);
      chk("idle100_rst", 32'(cpu_rst), 32'd0);
      chk("idle_pc", cpu_start_pc, RPC);
      chk("idle_err", 32'(error), 32'd0);
      chk("idle_rdy", 32'(rx_ready), 32'd0);

      // boot_req in RUN re-arms the loader
      boot_req = 1'b1;
      @(negedge clk);
      boot_req = 1'b0;
      chk("bootreq_rst", 32'(cpu_rst), 32'd1);
      chk("bootreq_rdy", 32'(rx_ready), 32'd1);

      // byte arriving in the expiry cycle wins over the timeout
      do_reset();
      repeat (98) @(negedge clk);
      rx_data  = 8'h00;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("prec_rst", 32'(cpu_rst), 32'd1);
      chk("prec_rdy", 32'(rx_ready), 32'd1);

      // stall inside ADDR
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h01);
      rx_valid = 1'b0;
      repeat (110) @(negedge clk);
      chk("atmo_err", 32'(error), 32'd1);
      chk("atmo_rst", 32'(cpu_rst), 32'd1);
      chk("atmo_rdy", 32'(rx_ready), 32'd1);
      chk("atmo_nwr", 32'(nwr), 32'd0);
      repeat (110) @(negedge clk);
      chk("atmo_wait_run", 32'(cpu_rst), 32'd0);
      chk("atmo_err_sticky", 32'(error), 32'd1);
      chk("atmo_pc", cpu_start_pc, RPC);

      // boot_req during DATA is ignored
      do_reset();
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h42);
      rx_valid = 1'b0;
      boot_req = 1'b1;
      @(negedge clk);
      boot_req = 1'b0;
      chk("bd_rdy", 32'(rx_ready), 32'd1);
      for (int i = 0; i < 3; i++) send_byte(8'h00);
      chk("bd_we", 32'(imem_we), 32'hF);
      chk("bd_addr", 32'(imem_addr), 32'd0);
      chk("bd_din", imem_din, 32'h42);
      send_byte(8'h43);
      rx_valid = 1'b0;
      chk("bd_done_rst", 32'(cpu_rst), 32'd1);
      @(negedge clk);
      chk("bd_run_rst", 32'(cpu_rst), 32'd0);
      chk("bd_pc", cpu_start_pc, 32'd0);
      chk("bd_err", 32'(error), 32'd0);
      chk("bd_nwr", 32'(nwr), 32'd1);

      // reset during a write pulse kills it at once
      do_reset();
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h42);
      for (int i = 0; i < 3; i++) send_byte(8'h00);
      rx_valid = 1'b0;
      chk("mr_we_pre", 32'(imem_we), 32'hF);
      rst = 1'b0;
      #1;
      chk("mr_we_post", 32'(imem_we), 32'd0);
      chk("mr_rst", 32'(cpu_rst), 32'd1);
      do_reset();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
